// File: rtl/ifu_display_top.sv
// Fetch unit (PC, +4, word ROM) stepped by a divided enable, shown on an 8-digit 7-seg scan.
// Define IFU_SHOW_PC_EN to show PC[15:0] on digits 7..4 and instruction[15:0] on 3..0.
module ifu_display_top #(
  parameter int CLK_DIV     = 50_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int IMEM_DEPTH  = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [6:0] out7,
  output logic [7:0] en_out
);

  localparam int FW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    k_q, k_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    en_q, en_d;

  logic          ftick;
  logic          rtick;
  logic [31:0]   instr;
  logic [31:0]   src;
  logic [3:0]    nib;

  // PC is idx_q with two zero LSBs; the ROM holds word i = i*3
  always_comb begin
    instr = 32'(idx_q) * 32'd3;
`ifdef IFU_SHOW_PC_EN
    src = {16'({idx_q, 2'b00}), instr[15:0]};
`else
    src = instr;
`endif
    nib = src[{k_q, 2'b00} +: 4];
  end

  always_comb begin
    ftick  = (fcnt_q == FW'(CLK_DIV - 1));
    rtick  = (rcnt_q == RW'(REFRESH_DIV - 1));
    fcnt_d = ftick ? '0 : fcnt_q + FW'(1);
    rcnt_d = rtick ? '0 : rcnt_q + RW'(1);
    idx_d  = idx_q;
    if (ftick) begin
      idx_d = (idx_q == AW'(IMEM_DEPTH - 1)) ? '0 : idx_q + AW'(1);
    end
    k_d    = rtick ? k_q + 3'd1 : k_q;
    en_d   = ~(8'b1 << k_q);
  end

  always_comb begin
    seg_d = 7'h40;
    unique case (nib)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
      default: seg_d = 7'h40;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fcnt_q <= '0;
      rcnt_q <= '0;
      idx_q  <= '0;
      k_q    <= '0;
      seg_q  <= 7'h40;
      en_q   <= 8'hFE;
    end else begin
      fcnt_q <= fcnt_d;
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      k_q    <= k_d;
      seg_q  <= seg_d;
      en_q   <= en_d;
    end
  end

  assign out7   = seg_q;
  assign en_out = en_q;

endmodule

// File: tb/tb_ifu_display_top.sv
// Random-run bench for ifu_display_top: two parameter sets checked
// against an arithmetic model of fetch/scan progress since reset.
module tb_ifu_display_top;

  localparam int CD_A = 4;
  localparam int RD_A = 2;
  localparam int DP_A = 4;
  localparam int CD_B = 1;
  localparam int RD_B = 3;
  localparam int DP_B = 128;

  localparam logic [6:0] HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_a, seg_b;
  logic [7:0] en_a, en_b;

  int n_chk;
  int n_err;
  int n;

  ifu_display_top #(
    .CLK_DIV(CD_A), .REFRESH_DIV(RD_A), .IMEM_DEPTH(DP_A)
  ) u_dut_a (
    .Clk(clk), .Rst(rst_n), .out7(seg_a), .en_out(en_a)
  );

  ifu_display_top #(
    .CLK_DIV(CD_B), .REFRESH_DIV(RD_B), .IMEM_DEPTH(DP_B)
  ) u_dut_b (
    .Clk(clk), .Rst(rst_n), .out7(seg_b), .en_out(en_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag,
                           input logic [7:0] obs,
                           input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Outputs after e clock edges since reset release show the
  // state reached after e-1 edges (registered display path).
  task automatic model(input int e, input int cd, input int rd,
                       input int dp, output logic [7:0] en,
                       output logic [6:0] seg);
    int m, idx, k;
    int unsigned pc, ins, src;
    m   = (e > 0) ? e - 1 : 0;
    idx = (m / cd) % dp;
    k   = (m / rd) % 8;
    pc  = idx * 4;
    ins = idx * 3;
`ifdef IFU_SHOW_PC_EN
    src = ((pc & 32'hFFFF) << 16) | (ins & 32'hFFFF);
`else
    src = ins;
`endif
    en  = ~(8'd1 << k);
    seg = HEX[(src >> (4 * k)) & 15];
  endtask

  task automatic check_all(input string tag);
    logic [7:0] en;
    logic [6:0] seg;
    model(n, CD_A, RD_A, DP_A, en, seg);
    expect_eq({tag, "_en_a"}, en_a, en);
    expect_eq({tag, "_seg_a"}, {1'b0, seg_a}, {1'b0, seg});
    model(n, CD_B, RD_B, DP_B, en, seg);
    expect_eq({tag, "_en_b"}, en_b, en);
    expect_eq({tag, "_seg_b"}, {1'b0, seg_b}, {1'b0, seg});
  endtask

  task automatic check_reset(input string tag);
    expect_eq({tag, "_en_a"}, en_a, 8'hFE);
    expect_eq({tag, "_seg_a"}, {1'b0, seg_a}, 8'h40);
    expect_eq({tag, "_en_b"}, en_b, 8'hFE);
    expect_eq({tag, "_seg_b"}, {1'b0, seg_b}, 8'h40);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    n     = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");

    for (int ep = 0; ep < 6; ep++) begin
      int len;
      int hold;
      len   = (ep == 0) ? 80 : int'($urandom_range(10, 70));
      hold  = int'($urandom_range(1, 3));
      n     = 0;
      rst_n = 1'b1;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        check_all("run");
      end
      @(posedge clk);
      #(int'($urandom_range(1, 3)));
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      repeat (hold) @(negedge clk);
      check_reset("rst_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
